// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared bank-select type, bank-state constants and clog2 helper for the ping-pong buffer
package pingpong_pkg;
  typedef enum logic {BANK0 = 1'b0, BANK1 = 1'b1} bank_sel_t;
  localparam logic BANK_EMPTY = 1'b0;
  localparam logic BANK_FULL = 1'b1;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/pingpong_bank_ram.sv
// pingpong_bank_ram: 1W1R RAM bank, DEPTH x DATA_W, synchronous read with resettable output register
//  clk/resetn           clock, async active-low reset (output register only)
//  i_we/i_waddr/i_wdata write port
//  i_re/i_raddr         read request; o_rdata updates the cycle after i_re and holds otherwise
module pingpong_bank_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/pingpong_stream_buffer.sv
// pingpong_stream_buffer: double-buffered valid/ready stream buffer, banks swap when filled/drained
//  clk, resetn             clock, async active-low reset
//  wr_valid/wr_ready/wr_data  producer side
//  rd_valid/rd_ready/y/rd_last consumer side; rd_last marks the final word of a bank
//  bank_full               per-bank full flags
//  flush                   present only with PINGPONG_FLUSH_EN: commits a partially filled bank
module pingpong_stream_buffer
  import pingpong_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] y,
  output logic              rd_last,
  output logic [1:0]        bank_full
`ifdef PINGPONG_FLUSH_EN
  ,
  input  logic              flush
`endif
);
  bank_sel_t r_wsel, r_rsel, r_ysel;
  logic [ADDR_W-1:0] r_waddr, r_raddr;
  logic [1:0] r_full;
  logic r_rd_valid, r_rd_last;
  logic [ADDR_W:0] w_len;
  logic w_wr_fire, w_commit, w_rd_issue, w_rd_end;
  logic [1:0] w_set, w_clr;
  logic [DATA_W-1:0] w_rdata [2];
  assign wr_ready = r_full[r_wsel] == BANK_EMPTY;
  assign w_wr_fire = wr_valid && wr_ready;
`ifdef PINGPONG_FLUSH_EN
  logic [ADDR_W:0] r_len [2];
  logic [ADDR_W:0] w_wcnt;
  // word count includes a word accepted in the same cycle as the flush
  assign w_wcnt = {1'b0, r_waddr} + (ADDR_W+1)'(w_wr_fire);
  assign w_commit = (w_wr_fire && r_waddr == ADDR_W'(DEPTH - 1)) || (flush && wr_ready && w_wcnt != '0);
  assign w_len = r_len[r_rsel];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_len[0] <= (ADDR_W+1)'(DEPTH);
      r_len[1] <= (ADDR_W+1)'(DEPTH);
    end else if (w_commit) r_len[r_wsel] <= w_wcnt;
  end
`else
  assign w_commit = w_wr_fire && r_waddr == ADDR_W'(DEPTH - 1);
  assign w_len = (ADDR_W+1)'(DEPTH);
`endif
  // fetch the next word whenever the output register is empty or being consumed
  assign w_rd_issue = r_full[r_rsel] == BANK_FULL && (!r_rd_valid || rd_ready);
  assign w_rd_end = w_rd_issue && {1'b0, r_raddr} == w_len - 1'b1;
  // writer and reader never share a bank, so set and clear never collide
  assign w_set = {r_wsel == BANK1, r_wsel == BANK0} & {2{w_commit}};
  assign w_clr = {r_rsel == BANK1, r_rsel == BANK0} & {2{w_rd_end}};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wsel <= BANK0;
      r_rsel <= BANK0;
      r_ysel <= BANK0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_full <= {BANK_EMPTY, BANK_EMPTY};
      r_rd_valid <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_commit) begin
        r_waddr <= '0;
        r_wsel <= r_wsel == BANK0 ? BANK1 : BANK0;
      end else if (w_wr_fire) r_waddr <= r_waddr + 1'b1;
      if (w_rd_issue) begin
        r_raddr <= w_rd_end ? '0 : r_raddr + 1'b1;
        r_ysel <= r_rsel;
        r_rd_valid <= 1'b1;
        r_rd_last <= w_rd_end;
        if (w_rd_end) r_rsel <= r_rsel == BANK0 ? BANK1 : BANK0;
      end else if (rd_ready) begin
        r_rd_valid <= 1'b0;
        r_rd_last <= 1'b0;
      end
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .resetn  (resetn),
      .i_we    (w_wr_fire && r_wsel == bank_sel_t'(b)),
      .i_waddr (r_waddr),
      .i_wdata (wr_data),
      .i_re    (w_rd_issue && r_rsel == bank_sel_t'(b)),
      .i_raddr (r_raddr),
      .o_rdata (w_rdata[b])
    );
  end
  // output register is the RAM read register of the bank last fetched from
  assign y = w_rdata[r_ysel];
  assign rd_valid = r_rd_valid;
  assign rd_last = r_rd_last;
  assign bank_full = r_full;
endmodule

// File: tb/tb_pingpong_stream_buffer.sv
// tb_pingpong_stream_buffer: randomized self-checking bench with a queue-based reference model
module tb_pingpong_stream_buffer;
  localparam int D = 32;
  logic clk = 0, resetn = 0, wr_valid = 0, rd_ready = 0;
  logic [7:0] wr_data = 0;
  logic wr_ready, rd_valid, rd_last;
  logic [7:0] y;
  logic [1:0] bank_full;
`ifdef PINGPONG_FLUSH_EN
  logic flush = 0;
`endif
  int checks = 0, failures = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pend_q[$];
  logic wf, rf, rv, yl;
  logic [7:0] yv;

  pingpong_stream_buffer #(.DATA_W(8), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .y(y), .rd_last(rd_last), .bank_full(bank_full)
`ifdef PINGPONG_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  // one cycle: drive at negedge, sample mid-cycle, update model, return #1 after posedge
  task automatic tick(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
    int n;
    @(negedge clk);
    wr_valid = wv; wr_data = wd; rd_ready = rr;
`ifdef PINGPONG_FLUSH_EN
    flush = fl;
`endif
    #1;
    wf = wv && wr_ready; rf = rd_valid && rr; rv = rd_valid; yv = y; yl = rd_last;
    if (wf) pend_q.push_back(wd);
    if (pend_q.size() == D || (fl && pend_q.size() != 0)) begin
      n = pend_q.size();
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, pend_q[i]});
      pend_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_valid = 0; rd_ready = 0;
`ifdef PINGPONG_FLUSH_EN
    flush = 0;
`endif
    resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    exp_q.delete(); pend_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_valid !== 1'b0 || y !== 8'h00 || rd_last !== 1'b0) begin
      failures++; $display("FAIL reset_out: got valid=%b y=%h last=%b, required 0 00 0", rd_valid, y, rd_last);
    end
    checks++;
    if (bank_full !== 2'b00 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL reset_flags: got full=%b wr_ready=%b, required 00 1", bank_full, wr_ready);
    end
  endtask

  task automatic test_fill();
    int acc = 0;
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 32; i++) begin tick(1, 8'(i), 0, 0); if (wf) acc++; end
    checks++;
    if (bank_full !== 2'b01 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL fill_one: got full=%b wr_ready=%b, required 01 1", bank_full, wr_ready);
    end
    for (int i = 32; i < 64; i++) begin tick(1, 8'(i), 0, 0); if (wf) acc++; end
    checks++;
    if (bank_full !== 2'b11 || wr_ready !== 1'b0 || acc != 64) begin
      failures++; $display("FAIL fill_two: got full=%b wr_ready=%b accepted=%0d, required 11 0 64", bank_full, wr_ready, acc);
    end
    checks++;
    if (rd_valid !== 1'b1 || y !== 8'h00) begin
      failures++; $display("FAIL fill_hold: got valid=%b y=%h, required 1 00", rd_valid, y);
    end
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      tick(0, 0, 1, 0);
      if (rf) begin
        e = exp_q.pop_front();
        checks++;
        if ({yl, yv} !== e) begin
          failures++; $display("FAIL fill_read: got last=%b y=%h, required last=%b y=%h", yl, yv, e[8], e[7:0]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || rd_valid !== 1'b0 || bank_full !== 2'b00) begin
      failures++; $display("FAIL fill_drain: got left=%0d valid=%b full=%b, required 0 0 00", exp_q.size(), rd_valid, bank_full);
    end
  endtask

  task automatic test_continuous();
    int nw = 0, nr = 0, gaps = 0, stalls = 0, t_commit = -1, t_first = -1;
    logic want;
    do_reset();
    for (int t = 0; t < 600 && nr < 256; t++) begin
      want = nw < 256;
      tick(want, 8'(nw), 1, 0);
      if (want && !wf) stalls++;
      if (wf) begin nw++; if (nw == 32) t_commit = t; end
      if (rf) begin
        checks++;
        if (yv !== 8'(nr) || yl !== 1'(nr % 32 == 31)) begin
          failures++; $display("FAIL stream_word: got y=%h last=%b, required y=%h last=%b", yv, yl, 8'(nr), nr % 32 == 31);
        end
        if (t_first < 0) t_first = t;
        nr++;
      end else if (t_first >= 0) gaps++;
    end
    checks++;
    if (nr != 256 || gaps != 0 || stalls != 0) begin
      failures++; $display("FAIL stream_rate: got reads=%0d gaps=%0d stalls=%0d, required 256 0 0", nr, gaps, stalls);
    end
    checks++;
    if (t_first - t_commit != 2) begin
      failures++; $display("FAIL first_latency: got %0d cycles, required 2", t_first - t_commit);
    end
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [1:0] prev = 2'b00;
    logic seen = 0;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      tick(1, 8'($urandom), 1, 0);
      if (prev == 2'b01 && bank_full == 2'b10) seen = 1;
      prev = bank_full;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL simul_swap: got transition 01->10 seen=%b, required 1", seen);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic wv, rr, ph = 0;
    logic [7:0] py = 0;
    logic [8:0] e;
    do_reset();
    for (int t = 0; t < 800; t++) begin
      wv = 1'($urandom_range(0, 1));
      rr = $urandom_range(0, 2) == 0;
      tick(wv, 8'($urandom), rr, 0);
      if (ph) begin
        checks++;
        if (rv !== 1'b1 || yv !== py) begin
          failures++; $display("FAIL bp_hold: got valid=%b y=%h, required 1 %h", rv, yv, py);
        end
      end
      if (rf) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_read: got y=%h, required no word", yv);
        end else begin
          e = exp_q.pop_front();
          if ({yl, yv} !== e) begin
            failures++; $display("FAIL bp_read: got last=%b y=%h, required last=%b y=%h", yl, yv, e[8], e[7:0]);
          end
        end
      end
      ph = rv && !rr;
      py = yv;
    end
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      tick(0, 0, 1, 0);
      if (rf) begin
        e = exp_q.pop_front();
        checks++;
        if ({yl, yv} !== e) begin
          failures++; $display("FAIL bp_drain: got last=%b y=%h, required last=%b y=%h", yl, yv, e[8], e[7:0]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL bp_loss: got %0d words unread, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 49; i++) tick(1, 8'(8'hA0 + i), 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b1 || y !== 8'hA0 || bank_full !== 2'b01) begin
      failures++; $display("FAIL mid_pre: got valid=%b y=%h full=%b, required 1 a0 01", rd_valid, y, bank_full);
    end
    @(negedge clk);
    #2 resetn = 0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || y !== 8'h00 || rd_last !== 1'b0 || bank_full !== 2'b00 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL mid_async: got valid=%b y=%h last=%b full=%b wr_ready=%b, required 0 00 0 00 1", rd_valid, y, rd_last, bank_full, wr_ready);
    end
    @(negedge clk);
    resetn = 1;
    exp_q.delete(); pend_q.delete();
    for (int i = 0; i < 32; i++) tick(1, 8'(8'h50 + i), 0, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    checks++;
    if (bank_full !== 2'b01 || rd_valid !== 1'b1 || y !== 8'h50) begin
      failures++; $display("FAIL mid_restart: got full=%b valid=%b y=%h, required 01 1 50", bank_full, rd_valid, y);
    end
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      tick(0, 0, 1, 0);
      if (rf) begin
        e = exp_q.pop_front();
        checks++;
        if ({yl, yv} !== e) begin
          failures++; $display("FAIL mid_read: got last=%b y=%h, required last=%b y=%h", yl, yv, e[8], e[7:0]);
        end
      end
    end
  endtask

`ifdef PINGPONG_FLUSH_EN
  task automatic test_flush();
    int nr = 0;
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 8'(8'h30 + i), 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    checks++;
    if (bank_full !== 2'b01) begin
      failures++; $display("FAIL flush_commit: got full=%b, required 01", bank_full);
    end
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
      tick(0, 0, 1, 0);
      if (rf) begin
        e = exp_q.pop_front();
        nr++;
        checks++;
        if ({yl, yv} !== e) begin
          failures++; $display("FAIL flush_read: got last=%b y=%h, required last=%b y=%h", yl, yv, e[8], e[7:0]);
        end
      end
    end
    checks++;
    if (nr != 5 || bank_full !== 2'b00) begin
      failures++; $display("FAIL flush_count: got reads=%0d full=%b, required 5 00", nr, bank_full);
    end
    for (int i = 0; i < 32; i++) tick(1, 8'($urandom), 1, 0);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      tick(0, 0, 1, 0);
      if (rf) begin
        e = exp_q.pop_front();
        checks++;
        if ({yl, yv} !== e) begin
          failures++; $display("FAIL flush_next: got last=%b y=%h, required last=%b y=%h", yl, yv, e[8], e[7:0]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL flush_next_loss: got %0d words unread, required 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_continuous();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
`ifdef PINGPONG_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
